if_stage: RTL

//  Instruction-fetch stage for the pipelined LoongArch core; sits directly upstream of decode (ID).

---
 rtl/if_stage.sv | 63 ++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the synchronous inst SRAM and
// hands {pc, inst} to ID, holding the SRAM word in a skid buffer while ID stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        to_fs_valid;
    logic        fs_valid;
    logic        fs_allowin;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        buf_valid;
    logic [31:0] inst_buf;

    // Pre-IF: next fetch address and SRAM request.
    assign to_fs_valid     = ~reset;
    assign seq_pc          = fs_pc + 32'd4;
    assign nextpc          = br_taken ? br_target : seq_pc;
    assign inst_sram_en    = to_fs_valid & (fs_allowin | br_taken);
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = '0;

    // IF stage: always ready to go, so allowin depends only on occupancy and ID.
    assign fs_allowin      = ~fs_valid | ds_allowin;
    assign fs_to_ds_valid  = fs_valid & ~br_taken;
    assign fs_inst         = buf_valid ? inst_buf : inst_sram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid  <= 1'b0;
            fs_pc     <= RESET_PC - 32'd4;
            buf_valid <= 1'b0;
        end else if (br_taken) begin
            fs_valid  <= 1'b1;
            fs_pc     <= br_target;
            buf_valid <= 1'b0;
        end else if (fs_allowin && to_fs_valid) begin
            fs_valid  <= 1'b1;
            fs_pc     <= seq_pc;
            buf_valid <= 1'b0;
        end else if (!buf_valid) begin
            // First stall cycle: the SRAM word is valid only now, so capture it.
            inst_buf  <= inst_sram_rdata;
            buf_valid <= 1'b1;
        end
    end

endmodule
